// File: rtl/masked_subbytes_ctrl.sv
// Masked AES SubBytes sequencer: streams a 2-share 128-bit state through a dual-lane masked
// GF(2^8) inverter two bytes per cycle and gathers the affine-mapped result shares.

module GF256Inv_Unit (
  input  logic       clk,
  input  logic [7:0] rnd,
  input  logic [7:0] aSh0,
  input  logic [7:0] aSh1,
  input  logic [7:0] bSh0,
  input  logic [7:0] bSh1,
  output logic [7:0] qaSh0,
  output logic [7:0] qaSh1,
  output logic [7:0] qbSh0,
  output logic [7:0] qbSh1
);
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sqN(input logic [7:0] x, input int n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = gfMul(y, y);
    return y;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Domain-oriented product: {x0*y0, x1*y1, x0*y1^r, x1*y0^r}; the cross terms are
  // registered with the mask before any share recombination takes place.
  function automatic logic [31:0] dom(input logic [7:0] x0, input logic [7:0] x1,
                                      input logic [7:0] y0, input logic [7:0] y1,
                                      input logic [7:0] r);
    return {gfMul(x0, y0), gfMul(x1, y1), gfMul(x0, y1) ^ r, gfMul(x1, y0) ^ r};
  endfunction

  function automatic logic [7:0] sh0(input logic [31:0] t);
    return t[31:24] ^ t[15:8];
  endfunction

  function automatic logic [7:0] sh1(input logic [31:0] t);
    return t[23:16] ^ t[7:0];
  endfunction

  logic [7:0] inSh0 [2];
  logic [7:0] inSh1 [2];
  logic [7:0] outSh0 [2];
  logic [7:0] outSh1 [2];

  assign inSh0[0] = aSh0;
  assign inSh1[0] = aSh1;
  assign inSh0[1] = bSh0;
  assign inSh1[1] = bSh1;
  assign qaSh0 = outSh0[0];
  assign qaSh1 = outSh1[0];
  assign qbSh0 = outSh0[1];
  assign qbSh1 = outSh1[1];

  // x^-1 = x^254 = x^2*x^4*...*x^128: squarings are linear per share, six products in a
  // depth-3 tree; five register stages in total.
  for (genvar gi = 0; gi < 2; gi++) begin : gLane
    logic [7:0]  x0Reg, x1Reg, t0Reg, t1Reg, y0Reg, y1Reg;
    logic [31:0] m1Reg, m2Reg, m3Reg, m4Reg, m5Reg, m6Reg;

    always_ff @(posedge clk) begin
      x0Reg <= inSh0[gi];
      x1Reg <= inSh1[gi];
      m1Reg <= dom(sqN(x0Reg, 1), sqN(x1Reg, 1), sqN(x0Reg, 2), sqN(x1Reg, 2), rotl(rnd, gi));
      m2Reg <= dom(sqN(x0Reg, 3), sqN(x1Reg, 3), sqN(x0Reg, 4), sqN(x1Reg, 4), rotl(rnd, gi + 2));
      m3Reg <= dom(sqN(x0Reg, 5), sqN(x1Reg, 5), sqN(x0Reg, 6), sqN(x1Reg, 6), rotl(rnd, gi + 4));
      t0Reg <= sqN(x0Reg, 7);
      t1Reg <= sqN(x1Reg, 7);
      m4Reg <= dom(sh0(m1Reg), sh1(m1Reg), sh0(m2Reg), sh1(m2Reg), rotl(rnd, gi + 1));
      m5Reg <= dom(sh0(m3Reg), sh1(m3Reg), t0Reg, t1Reg, rotl(rnd, gi + 3));
      m6Reg <= dom(sh0(m4Reg), sh1(m4Reg), sh0(m5Reg), sh1(m5Reg), rotl(rnd, gi + 5));
      y0Reg <= sh0(m6Reg);
      y1Reg <= sh1(m6Reg);
    end

    assign outSh0[gi] = y0Reg;
    assign outSh1[gi] = y1Reg;
  end
endmodule

// The inverter works natively in polynomial basis, so the basis change is the identity
// and only the AES affine matrix plus the share's constant remain.
module AffineOutput_Unit #(
  parameter logic [7:0] CONST = 8'h00
) (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  assign dout = din ^ {din[6:0], din[7]} ^ {din[5:0], din[7:6]}
              ^ {din[4:0], din[7:5]} ^ {din[3:0], din[7:4]} ^ CONST;
endmodule

module masked_subbytes_ctrl #(
  parameter int INV_LAT = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] state_sh0,
  input  logic [127:0] state_sh1,
  input  logic [7:0]   rnd_in,
  output logic         rnd_req,
  output logic         busy,
  output logic         out_valid,
  output logic [127:0] sbox_sh0,
  output logic [127:0] sbox_sh1
);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3;

  logic [1:0]         stateReg;
  logic [2:0]         kReg;
  logic [127:0]       in0Reg, in1Reg, res0Reg, res1Reg;
  logic [INV_LAT-1:0] vldReg;
  logic [2:0]         tagReg [INV_LAT];
  logic               issue, exitVld;
  logic [2:0]         exitTag;
  logic [7:0]         invA [2];
  logic [7:0]         invB [2];
  logic [7:0]         affA [2];
  logic [7:0]         affB [2];

  assign issue   = (stateReg == ISSUE);
  assign exitVld = vldReg[INV_LAT-1];
  assign exitTag = tagReg[INV_LAT-1];

  GF256Inv_Unit uInv (
    .clk   (clk),
    .rnd   (rnd_in),
    .aSh0  (in0Reg[{kReg, 4'b0000} +: 8]),
    .aSh1  (in1Reg[{kReg, 4'b0000} +: 8]),
    .bSh0  (in0Reg[{kReg, 4'b1000} +: 8]),
    .bSh1  (in1Reg[{kReg, 4'b1000} +: 8]),
    .qaSh0 (invA[0]),
    .qaSh1 (invA[1]),
    .qbSh0 (invB[0]),
    .qbSh1 (invB[1])
  );

  for (genvar gi = 0; gi < 2; gi++) begin : gAff
    localparam logic [7:0] C = (gi == 0) ? 8'h63 : 8'h00;
    AffineOutput_Unit #(.CONST(C)) uAffA (.din(invA[gi]), .dout(affA[gi]));
    AffineOutput_Unit #(.CONST(C)) uAffB (.din(invB[gi]), .dout(affB[gi]));
  end

  // Tags need no reset: only their valid bits decide whether they are used.
  always_ff @(posedge clk) begin
    tagReg[0] <= kReg;
    for (int i = 1; i < INV_LAT; i++) tagReg[i] <= tagReg[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      kReg     <= 3'd0;
      vldReg   <= '0;
      res0Reg  <= '0;
      res1Reg  <= '0;
    end else begin
      vldReg[0] <= issue;
      for (int i = 1; i < INV_LAT; i++) vldReg[i] <= vldReg[i-1];
      if (exitVld) begin
        res0Reg[{exitTag, 4'b0000} +: 8] <= affA[0];
        res0Reg[{exitTag, 4'b1000} +: 8] <= affB[0];
        res1Reg[{exitTag, 4'b0000} +: 8] <= affA[1];
        res1Reg[{exitTag, 4'b1000} +: 8] <= affB[1];
      end
      case (stateReg)
        IDLE: if (start) begin
          in0Reg   <= state_sh0;
          in1Reg   <= state_sh1;
          kReg     <= 3'd0;
          stateReg <= ISSUE;
        end
        ISSUE: begin
          kReg <= kReg + 3'd1;
          if (kReg == 3'd7) stateReg <= DRAIN;
        end
        DRAIN: if (exitVld && exitTag == 3'd7) stateReg <= DONE;
        DONE: stateReg <= IDLE;
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign busy      = (stateReg != IDLE);
  assign out_valid = (stateReg == DONE);
  assign rnd_req   = |vldReg;
  assign sbox_sh0  = res0Reg;
  assign sbox_sh1  = res1Reg;
endmodule

// File: tb/tb_masked_subbytes_ctrl.sv
// Scoreboard bench for masked_subbytes_ctrl: directed jobs push expected recombined results
// and completion cycles; a negedge monitor pops and checks on every out_valid.

module tb_masked_subbytes_ctrl;
  localparam logic [127:0] FIPS_IN  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] FIPS_OUT = 128'h1628c14beaaceec4f533fc1bc3938263;
  localparam logic [127:0] ALL63    = {16{8'h63}};
  localparam logic [127:0] ONES     = {16{8'h01}};
  localparam logic [127:0] ALL7C    = {16{8'h7c}};

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [127:0] state_sh0, state_sh1;
  logic [7:0]   rnd_in = 8'h00;
  logic         rnd_req, busy, out_valid;
  logic [127:0] sbox_sh0, sbox_sh1;

  typedef struct {
    logic [127:0] data;
    int           cyc;
    bit           chkMask;
  } exp_t;

  exp_t         sbq [$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           txn = 0;
  logic [127:0] prevSh1 = '0;

  masked_subbytes_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .state_sh0 (state_sh0),
    .state_sh1 (state_sh1),
    .rnd_in    (rnd_in),
    .rnd_req   (rnd_req),
    .busy      (busy),
    .out_valid (out_valid),
    .sbox_sh0  (sbox_sh0),
    .sbox_sh1  (sbox_sh1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rnd_in = 8'($urandom);

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic waitTo(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Called at a negedge; start is sampled at the following posedge (E0 ends cycle e0).
  task automatic launch(input logic [127:0] plain, input logic [127:0] mask,
                        input logic [127:0] exp, input bit chkMask, output int e0);
    exp_t e;
    state_sh1 = mask;
    state_sh0 = plain ^ mask;
    start = 1'b1;
    e0 = cyc;
    e.data = exp;
    e.cyc = e0 + 14;
    e.chkMask = chkMask;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        txn++;
        $display("txn %0d cycle %0d result %h", txn, cyc, sbox_sh0 ^ sbox_sh1);
        if ((sbox_sh0 ^ sbox_sh1) !== e.data) begin
          errors++;
          $display("FAIL result: got %h expected %h", sbox_sh0 ^ sbox_sh1, e.data);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL out_valid_cycle: got %0d expected %0d", cyc, e.cyc);
        end
        if (e.chkMask) begin
          checks++;
          if (sbox_sh1 === prevSh1) begin
            errors++;
            $display("FAIL mask_sh1_repeat: got %h expected a value differing from %h", sbox_sh1, prevSh1);
          end
        end
        prevSh1 = sbox_sh1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1;
    rst_n = 1'b0;
    start = 1'b0;
    state_sh0 = '0;
    state_sh1 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_rnd_req", 128'(rnd_req), 128'(0));
    check("reset_sbox_sh0", sbox_sh0, '0);
    check("reset_sbox_sh1", sbox_sh1, '0);

    // All-zero shares
    launch('0, '0, ALL63, 1'b0, e0);
    waitTo(e0 + 15);

    // FIPS vector with busy window and rnd_req checks
    launch(FIPS_IN, rand128(), FIPS_OUT, 1'b0, e0);
    check("busy_first_issue", 128'(busy), 128'(1));
    check("rnd_req_cycle1", 128'(rnd_req), 128'(0));
    waitTo(e0 + 3);
    check("rnd_req_in_flight", 128'(rnd_req), 128'(1));
    waitTo(e0 + 14);
    check("busy_done_cycle", 128'(busy), 128'(1));
    waitTo(e0 + 15);
    check("busy_after_done", 128'(busy), 128'(0));
    check("rnd_req_after_done", 128'(rnd_req), 128'(0));

    // Masking independence: fresh sh1 and rnd_in each run
    for (int i = 0; i < 100; i++) begin
      launch(FIPS_IN, rand128(), FIPS_OUT, 1'b1, e0);
      waitTo(e0 + 15);
    end

    // Starts while busy are ignored; start at cycle 15 launches the next job
    launch(FIPS_IN, rand128(), FIPS_OUT, 1'b0, e0);
    waitTo(e0 + 3);
    start = 1'b1;
    state_sh0 = ~state_sh0;
    state_sh1 = rand128();
    @(negedge clk);
    start = 1'b0;
    waitTo(e0 + 14);
    start = 1'b1;
    state_sh0 = rand128();
    @(negedge clk);
    launch('0, rand128(), ALL63, 1'b0, e1);
    waitTo(e1 + 15);

    // Reset in the middle of a job abandons it
    launch(FIPS_IN, rand128(), FIPS_OUT, 1'b0, e0);
    waitTo(e0 + 7);
    rst_n = 1'b0;
    void'(sbq.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_busy", 128'(busy), 128'(0));
    check("midreset_out_valid", 128'(out_valid), 128'(0));
    check("midreset_rnd_req", 128'(rnd_req), 128'(0));
    check("midreset_sbox_sh0", sbox_sh0, '0);
    check("midreset_sbox_sh1", sbox_sh1, '0);
    waitTo(e0 + 30);
    launch(ONES, rand128(), ALL7C, 1'b0, e0);
    waitTo(e0 + 15);

    for (int i = 0; i < 50 && sbq.size() > 0; i++) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_results: got %0d outstanding expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
